ahb_lsu_master: RTL and testbench

Load/store front end that converts the core's simple valid/ready memory requests into AHB-Lite master transfers for the on-chip memory slave. It issues pipelined single transfers (address phase overlapping the previous data phase), replicates store data onto byte lanes, honours HREADY wait states, and returns load data aligned, sign- or zero-extended, with a one-cycle registered response.

---
 rtl/ahb_lsu_master.sv | 92 +++++++++
 tb/tb_ahb_lsu_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lsu_master.sv
// ahb_lsu_master: core load/store requests to pipelined AHB-Lite single transfers
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module ahb_lsu_master #(
    parameter int ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [31:0]       HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [31:0]       HWDATA,
    input  logic              HREADY,
    input  logic [31:0]       HRDATA
);
    typedef enum logic {IDLE, DATA} state_t;
    state_t state, state_next;
    logic dp_active, dp_write, dp_unsigned, misaligned, accept, trap, complete;
    logic [1:0] dp_size, dp_addr;
    logic [7:0] lane_b;
    logic [15:0] lane_h;
    logic [31:0] wdata_rep, load_data;

    // Misalignment only matters when the trap is built in; otherwise the slave sees raw low bits
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = (req_size == 2'b01 & req_addr[0]) | (req_size[1] & |req_addr[1:0]);
`else
        misaligned = 1'b0;
`endif
    end

    assign dp_active = state == DATA;
    // A trapped request must wait for the bus response slot to be free
    assign req_ready = HREADY & ~HRESET & ~(misaligned & dp_active);
    assign accept    = req_valid & req_ready & ~misaligned;
    assign trap      = req_valid & req_ready & misaligned;
    assign complete  = dp_active & HREADY;
    assign HTRANS    = accept ? 2'b10 : 2'b00;
    assign HSIZE     = {1'b0, req_size};
    assign HADDR     = 32'(req_addr);
    assign HWRITE    = req_write;
    assign wdata_rep = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                       req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    assign lane_b    = HRDATA[{dp_addr, 3'b000} +: 8];
    assign lane_h    = dp_addr[1] ? HRDATA[31:16] : HRDATA[15:0];
    assign load_data = dp_size == 2'b00 ? {{24{~dp_unsigned & lane_b[7]}}, lane_b} :
                       dp_size == 2'b01 ? {{16{~dp_unsigned & lane_h[15]}}, lane_h} : HRDATA;

    // Data phase advances only on HREADY; a fresh accept keeps it occupied back-to-back
    always_comb begin
        state_next = state;
        if (HREADY) state_next = accept ? DATA : IDLE;
    end

    // State, data-phase context and the registered response
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= IDLE;
            dp_write    <= 1'b0;
            dp_unsigned <= 1'b0;
            dp_size     <= 2'b00;
            dp_addr     <= 2'b00;
            HWDATA      <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                dp_write    <= req_write;
                dp_unsigned <= req_unsigned;
                dp_size     <= req_size;
                dp_addr     <= req_addr[1:0];
                HWDATA      <= wdata_rep;
            end
            resp_valid <= complete | trap;
            resp_rdata <= complete & ~dp_write ? load_data : '0;
            resp_err   <= trap;
        end
    end
endmodule

// File: tb/tb_ahb_lsu_master.sv
// tb_ahb_lsu_master: randomized and directed checks against a byte-memory reference model
module tb_ahb_lsu_master;
    logic        HCLK = 1'b0, HRESET = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = 2'b00;
    logic        resp_valid, resp_err, HWRITE, HREADY;
    logic [31:0] resp_rdata, HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;

    always #5 HCLK = ~HCLK;

    ahb_lsu_master #(.ADDR_W(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA)
    );

    typedef struct {logic [31:0] rdata; logic err;} exp_t;
    exp_t expq[$];
    logic [7:0] smem [256];
    logic [7:0] mmem [256];
    int checks = 0, passed = 0;
    int wait_min = 0, wait_max = 0;
    logic s_act = 1'b0, s_wr = 1'b0;
    logic [7:0] s_addr = '0;
    logic [2:0] s_size = '0;
    int s_wait = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        return sz >= 3'd2 ? 4 : 1 << sz;
    endfunction

    // Reference: memory as bytes, loads assembled and extended arithmetically
    function automatic logic [31:0] model(input logic w, input logic [7:0] a, input logic [1:0] sz,
                                          input logic u, input logic [31:0] wd);
        int n = nbytes({1'b0, sz});
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++)
            if (w) mmem[8'(a + i)] = wd[8*i +: 8];
            else v[8*i +: 8] = mmem[8'(a + i)];
        if (w) return '0;
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    // AHB slave memory with per-transfer random wait states and byte-lane writes
    assign HREADY = ~s_act | (s_wait == 0);
    always_comb HRDATA = {smem[{s_addr[7:2], 2'd3}], smem[{s_addr[7:2], 2'd2}],
                          smem[{s_addr[7:2], 2'd1}], smem[{s_addr[7:2], 2'd0}]};
    always @(posedge HCLK) begin
        if (HRESET) s_act <= 1'b0;
        else if (HREADY) begin
            if (s_act && s_wr)
                for (int i = 0; i < 4; i++)
                    if (i >= int'(s_addr[1:0]) && i < int'(s_addr[1:0]) + nbytes(s_size))
                        smem[{s_addr[7:2], 2'(i)}] <= HWDATA[8*i +: 8];
            s_act  <= HTRANS[1];
            s_wr   <= HWRITE;
            s_addr <= HADDR[7:0];
            s_size <= HSIZE;
            s_wait <= int'($urandom_range(wait_max, wait_min));
        end else s_wait <= s_wait - 1;
    end

    always @(negedge HCLK) begin
        exp_t e;
        if (!HRESET && resp_valid) begin
            if (expq.size() == 0) chk("resp_unexpected", resp_valid, 0);
            else begin
                e = expq.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", resp_err, e.err);
            end
        end
    end

    task automatic poke(input logic [7:0] a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
            smem[a + 8'(i)] = v[8*i +: 8];
            mmem[a + 8'(i)] = v[8*i +: 8];
        end
    endtask

    task automatic send(input logic w, input logic [7:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd);
        int t = 0;
        exp_t e;
        req_valid = 1'b1; req_write = w; req_addr = {24'h0, a};
        req_size = sz; req_unsigned = u; req_wdata = wd;
        @(negedge HCLK);
        while (!req_ready && t < 100) begin t++; @(negedge HCLK); end
        chk("req_ready", req_ready, 1);
        chk("htrans", HTRANS, 2);
        chk("hsize", HSIZE, {1'b0, sz});
        chk("haddr", HADDR, {24'h0, a});
        chk("hwrite", HWRITE, w);
        e.rdata = model(w, a, sz, u, wd);
        e.err = 1'b0;
        expq.push_back(e);
        @(posedge HCLK); #1;
    endtask

    task automatic drain();
        int t = 0;
        req_valid = 1'b0;
        while (expq.size() != 0 && t < 200) begin t++; @(negedge HCLK); end
        chk("drain", expq.size(), 0);
        @(posedge HCLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            smem[i] = 8'($urandom);
            mmem[i] = smem[i];
        end
        req_valid = 1'b1; req_addr = 32'h10; req_size = 2'b10;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_hwdata", HWDATA, 0);
        chk("rst_htrans", HTRANS, 0);
        chk("rst_req_ready", req_ready, 0);
        @(posedge HCLK); #1;
        HRESET = 1'b0; req_valid = 1'b0;

        poke(8'h10, 32'hDEADBEEF);
        send(0, 8'h10, 2'b10, 0, 0);
        req_valid = 1'b0;
        @(negedge HCLK) chk("wl_resp_n1", resp_valid, 0);
        @(negedge HCLK) chk("wl_resp_n2", resp_valid, 1);
        chk("wl_rdata", resp_rdata, 32'hDEADBEEF);
        @(posedge HCLK); #1;

        send(1, 8'h13, 2'b00, 0, 32'h0000_00A5);
        req_valid = 1'b0;
        @(negedge HCLK) chk("sb_hwdata", HWDATA, 32'hA5A5A5A5);
        drain();
        send(0, 8'h13, 2'b00, 0, 0);
        req_valid = 1'b0;
        @(negedge HCLK); @(negedge HCLK) chk("lb_signed", resp_rdata, 32'hFFFFFFA5);
        @(posedge HCLK); #1;
        send(0, 8'h13, 2'b00, 1, 0);
        req_valid = 1'b0;
        @(negedge HCLK); @(negedge HCLK) chk("lb_unsigned", resp_rdata, 32'h000000A5);
        drain();

        wait_min = 2; wait_max = 2;
        send(1, 8'h24, 2'b10, 0, 32'h55667788);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK) chk("ws_hwdata_hold", HWDATA, 32'h55667788);
        end
        drain();
        poke(8'h20, 32'h80011234);
        send(0, 8'h22, 2'b01, 0, 0);
        req_valid = 1'b0;
        @(negedge HCLK) chk("wh_ready_n1", req_ready, 0);
        @(negedge HCLK) chk("wh_ready_n2", req_ready, 0);
        @(negedge HCLK) chk("wh_ready_n3", req_ready, 1);
        chk("wh_resp_n3", resp_valid, 0);
        @(negedge HCLK) chk("wh_resp_n4", resp_valid, 1);
        chk("wh_rdata", resp_rdata, 32'hFFFF8001);
        wait_min = 0; wait_max = 0;
        drain();

        send(1, 8'h00, 2'b10, 0, 32'h11223344);
        send(0, 8'h00, 2'b10, 0, 0);
        req_valid = 1'b0;
        @(negedge HCLK) chk("b2b_resp1", resp_valid, 1);
        chk("b2b_store_rdata", resp_rdata, 0);
        @(negedge HCLK) chk("b2b_resp2", resp_valid, 1);
        chk("b2b_load_rdata", resp_rdata, 32'h11223344);
        @(negedge HCLK) chk("b2b_resp3", resp_valid, 0);
        drain();

        send(0, 8'h10, 2'b10, 0, 32'hCAFEF00D);
        HRESET = 1'b1;
        expq.delete();
        @(negedge HCLK) chk("mr_htrans", HTRANS, 0);
        chk("mr_req_ready", req_ready, 0);
        @(posedge HCLK); #1;
        HRESET = 1'b0; req_valid = 1'b0;
        @(negedge HCLK) chk("mr_resp_valid", resp_valid, 0);
        chk("mr_resp_rdata", resp_rdata, 0);
        chk("mr_resp_err", resp_err, 0);
        chk("mr_hwdata", HWDATA, 0);
        @(negedge HCLK) chk("mr_resp_late", resp_valid, 0);
        @(posedge HCLK); #1;

`ifdef LSU_MISALIGN_TRAP_EN
        begin
            exp_t e;
            req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h2; req_size = 2'b10;
            @(negedge HCLK) chk("trap_ready", req_ready, 1);
            chk("trap_htrans", HTRANS, 0);
            e.rdata = '0; e.err = 1'b1;
            expq.push_back(e);
            @(posedge HCLK); #1;
            req_valid = 1'b0;
            @(negedge HCLK) chk("trap_resp_valid", resp_valid, 1);
            chk("trap_resp_err", resp_err, 1);
            chk("trap_resp_rdata", resp_rdata, 0);
            drain();
        end
`endif

        wait_min = 0; wait_max = 2;
        for (int k = 0; k < 300; k++) begin
            logic [1:0] sz;
            logic [7:0] a;
            sz = 2'($urandom_range(3, 0));
            a = 8'($urandom_range(63, 0)) & ~8'(nbytes({1'b0, sz}) - 1);
            send(1'($urandom), a, sz, 1'($urandom), $urandom);
            if ($urandom_range(2, 0) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(2, 1)) begin @(posedge HCLK); #1; end
            end
        end
        drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
